ifu_return_stack: RTL
=====================

// Module: ifu_return_stack
// PURPOSE
//  Speculative return-address stack (RAS) for the fetch predictor.
//  - Fetch pushes the return address on a predicted call and pops on a predicted ret.
//  - Execute confirms each call/ret after resolution, using c1_call_affirm_i / c1_ret_affirm_i driven from the branch unit's branch_type result.
//  - On flush, the speculative pointer is restored to the committed pointer.
//  - Addresses are word addresses, pc[31:2], 30 bits wide.
// PARAMETERS
//  DEPTH  8  Number of entries. Must be a power of two and >= 2. PW = $clog2(DEPTH).
// PORTS
//  cpu_clock_i        in   1     Clock. Single clock domain.
//  cpu_reset_n_i      in   1     Reset. Asynchronous assert, active-low.
//  fetch_vld_i        in   1     Fetch-block predictions below are valid this cycle.
//  fetch_call_i       in   1     Predicted call: push fetch_ret_addr_i.
//  fetch_ret_i        in   1     Predicted ret: pop.
//  fetch_ret_addr_i   in   30    Return word address, i.e. call pc + 1.
//  ras_top_o          out  30    Predicted return target = mem[spec_tos]; forced to 0 when !ras_vld_o.
//  ras_vld_o          out  1     spec_cnt != 0.
//  c1_call_affirm_i   in   1     Resolved call retired: committed push.
//  c1_ret_affirm_i    in   1     Resolved ret retired: committed pop.
//  flush_i            in   1     Pipeline flush: spec state <= committed state.
//  spec_cnt_o         out  PW+1  Speculative occupancy, 0..DEPTH.
// BEHAVIOUR
//  State:
//  - spec_tos, com_tos: PW bits each, wrap mod DEPTH.
//  - spec_cnt, com_cnt: PW+1 bits each, range 0..DEPTH.
//  - mem[DEPTH] of 30-bit entries. mem is not reset.
//  Reset values: all pointers and counts = 0. Therefore ras_vld_o = 0, ras_top_o = 0, spec_cnt_o = 0.
//  Outputs are combinational from registered state. A push or pop is visible on the cycle after it occurs.
//  Speculative update, applied only when fetch_vld_i && !flush_i:
//  - push only: spec_tos += 1; mem[spec_tos + 1] <= addr; spec_cnt = min(spec_cnt + 1, DEPTH).
//    At full, the oldest entry is overwritten silently.
//  - pop only, spec_cnt > 0: spec_tos -= 1; spec_cnt -= 1.
//  - pop only, spec_cnt == 0 (underflow): no state change.
//  - push and pop in the same cycle: treated as pop-then-push, i.e. replace the top.
//    mem[spec_tos] <= addr; spec_tos unchanged.
//    spec_cnt unchanged if > 0; if spec_cnt == 0, it becomes 1.
//  Committed update, unconditional on fetch_vld_i:
//  - Same pointer/count rules as speculative update, applied to com_tos / com_cnt.
//  - No mem write.
//  - Both affirms in the same cycle follow the replace rule.
//  Flush:
//  - spec_tos / spec_cnt <= the committed values AFTER this cycle's affirm update.
//  - Fetch ops in the flush cycle are dropped; mem is not written.
//  Committed entries overwritten by speculative pushes after wrap are not recovered. This is accepted prediction inaccuracy, not an error.
//  Reset asserted mid-operation clears all pointers and counts immediately.
//  Prediction only: this block raises no exceptions. The branch unit detects any wrong target.
// TESTING
//  1. Reset, then idle -> ras_vld_o = 0, ras_top_o = 0, spec_cnt_o = 0.
//  2. Push 0x100, push 0x200 -> top 0x200, cnt 2. Pop -> top 0x100. Pop -> vld 0. Pop again -> cnt stays 0.
//  3. DEPTH = 8: push 1..9 -> cnt 8, top 9. Then 8 pops -> tops 9,8,...,2 in turn, then vld 0.
//  4. Push 0xA, push 0xB; affirm one call; flush -> cnt 1, top 0xA.
//  5. Top 0x40 at cnt 3; call + ret same cycle with addr 0x80 -> top 0x80, cnt 3.
//  6. flush_i with fetch push in the same cycle -> push dropped; spec state equals committed state.

Source files
------------

// File: rtl/ifu_return_stack.sv
// Speculative return-address stack for the fetch predictor.
// Fetch pushes and pops speculatively; retired affirms track committed state for flush recovery.
module ifu_return_stack #(
   parameter int DEPTH = 8
) (
   input  logic                     cpu_clock_i,
   input  logic                     cpu_reset_n_i,
   input  logic                     fetch_vld_i,
   input  logic                     fetch_call_i,
   input  logic                     fetch_ret_i,
   input  logic [29:0]              fetch_ret_addr_i,
   output logic [29:0]              ras_top_o,
   output logic                     ras_vld_o,
   input  logic                     c1_call_affirm_i,
   input  logic                     c1_ret_affirm_i,
   input  logic                     flush_i,
   output logic [$clog2(DEPTH):0]   spec_cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef struct packed {
      logic [PW-1:0] tos;
      logic [PW:0]   cnt;
   } ptr_t;

   ptr_t spec_q, com_q;
   ptr_t spec_step, com_next, spec_next;
   logic [29:0] mem [DEPTH];
   logic fetch_en;

   // Both ops together act as pop-then-push, i.e. replace the top.
   function automatic ptr_t step(input ptr_t p, input logic push, input logic pop);
      ptr_t n;
      n = p;
      unique case ({push, pop})
         2'b10: begin
            n.tos = p.tos + 1'b1;
            n.cnt = (p.cnt == FULL) ? FULL : p.cnt + 1'b1;
         end
         2'b01: begin
            if (p.cnt != '0) begin
               n.tos = p.tos - 1'b1;
               n.cnt = p.cnt - 1'b1;
            end
         end
         2'b11: begin
            if (p.cnt == '0) n.cnt = (PW+1)'(1);
         end
         default: n = p;
      endcase
      return n;
   endfunction

   assign fetch_en = fetch_vld_i && !flush_i;

   always_comb begin
      com_next  = step(com_q, c1_call_affirm_i, c1_ret_affirm_i);
      spec_step = step(spec_q, fetch_call_i, fetch_ret_i);
      spec_next = spec_q;
      if (flush_i)       spec_next = com_next;
      else if (fetch_en) spec_next = spec_step;
   end

   always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
      if (!cpu_reset_n_i) begin
         spec_q <= '0;
         com_q  <= '0;
      end else begin
         spec_q <= spec_next;
         com_q  <= com_next;
      end
   end

   always_ff @(posedge cpu_clock_i) begin
      if (fetch_en && fetch_call_i) begin
         if (fetch_ret_i) mem[spec_q.tos]        <= fetch_ret_addr_i;
         else             mem[spec_q.tos + 1'b1] <= fetch_ret_addr_i;
      end
   end

   assign ras_vld_o  = (spec_q.cnt != '0);
   assign ras_top_o  = ras_vld_o ? mem[spec_q.tos] : 30'd0;
   assign spec_cnt_o = spec_q.cnt;

endmodule
